// File: rtl/display_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : display_capture_if
// Description : Bundle for the 4-digit multiplexed 7-segment capture port.
//               Carries the scanned display lines (an/seg), the clear
//               request and everything the capture block reports back.
//   an[3:0]        digit enables, active-low (an[i]=0 selects digit i)
//   seg[6:0]       segments, active-low, seg[0]=a ... seg[6]=g
//   clr            synchronous clear of valid / glyph_err / stale
//   d0..d3[3:0]    last decoded hex value per digit
//   valid[3:0]     digit captured since reset / clr / timeout
//   glyph_err[3:0] sticky: digit seen with a non-hex segment pattern
//   an_err         pulse: settled an pattern with several digits enabled
//   upd, upd_idx   pulse + index of the digit register just written
//   stale          watchdog flag (timeout build only)
// Modports    : master = display / stimulus side, slave = capture block
// Revision    : 1.0 - initial release
// ============================================================================
interface display_capture_if;
  logic [3:0] an;
  logic [6:0] seg;
  logic       clr;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] valid;
  logic [3:0] glyph_err;
  logic       an_err;
  logic       upd;
  logic [1:0] upd_idx;
  logic       stale;

  modport master (
    output an, seg, clr,
    input  d0, d1, d2, d3, valid, glyph_err, an_err, upd, upd_idx, stale
  );

  modport slave (
    input  an, seg, clr,
    output d0, d1, d2, d3, valid, glyph_err, an_err, upd, upd_idx, stale
  );
endinterface
`default_nettype wire

// File: rtl/display_capture.sv
`default_nettype none
// ============================================================================
// Module      : display_capture
// Description : Receiving end of a 4-digit multiplexed 7-segment display.
//               Synchronises the scanned an/seg lines, waits until the
//               pattern has been stable for STABLE_CYCLES samples, then
//               decodes the glyph back to hex and stores it per digit.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               bus   - display_capture_if.slave (an, seg, clr in;
//                       d0..d3, valid, glyph_err, an_err, upd, upd_idx,
//                       stale out)
// Parameters  : SYNC_STAGES    synchroniser depth (>=2)
//               STABLE_CYCLES  stable samples needed before capture (>=1)
//               TIMEOUT_CYCLES cycles without capture before data is stale
// Options     : `define DISP_CAP_TIMEOUT_EN builds the staleness watchdog;
//               without it stale is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module display_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  display_capture_if.slave  bus
);

  localparam int              PIN_W     = 11;
  localparam logic [PIN_W-1:0] PINS_IDLE = {4'hF, 7'h7F};
  localparam int              CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;

  // Out-of-range parameters instantiate a module that does not exist so the
  // build stops at elaboration instead of producing a broken netlist.
  generate
    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      display_capture_illegal_parameter u_illegal_parameter ();
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Glyph decoder: exact inverse of the hex_to_7seg table. Bit 4 = decodes.
  // --------------------------------------------------------------------------
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'h40:   decode_glyph = {1'b1, 4'h0};
      7'h79:   decode_glyph = {1'b1, 4'h1};
      7'h24:   decode_glyph = {1'b1, 4'h2};
      7'h30:   decode_glyph = {1'b1, 4'h3};
      7'h19:   decode_glyph = {1'b1, 4'h4};
      7'h12:   decode_glyph = {1'b1, 4'h5};
      7'h02:   decode_glyph = {1'b1, 4'h6};
      7'h78:   decode_glyph = {1'b1, 4'h7};
      7'h00:   decode_glyph = {1'b1, 4'h8};
      7'h10:   decode_glyph = {1'b1, 4'h9};
      7'h08:   decode_glyph = {1'b1, 4'hA};
      7'h03:   decode_glyph = {1'b1, 4'hB};
      7'h46:   decode_glyph = {1'b1, 4'hC};
      7'h21:   decode_glyph = {1'b1, 4'hD};
      7'h06:   decode_glyph = {1'b1, 4'hE};
      7'h0E:   decode_glyph = {1'b1, 4'hF};
      default: decode_glyph = 5'h00;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Input synchroniser. Preset to the blank pattern so reset looks like an
  // idle display rather than a spurious pin change.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q, sync_d;
  logic [PIN_W-1:0]                  prev_q, prev_d;
  logic [PIN_W-1:0]                  w_sample;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {bus.an, bus.seg}};
  end

  assign w_sample = sync_q[SYNC_STAGES-1];
  assign prev_d   = w_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{PINS_IDLE}};
      prev_q <= PINS_IDLE;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // --------------------------------------------------------------------------
  // Settle FSM. The counter holds (number of stable samples seen - 1); the
  // sample is evaluated in the cycle the count would reach STABLE_CYCLES-1,
  // which lands upd on edge SYNC_STAGES+STABLE_CYCLES after a pin change.
  // --------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_change;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_settled;
  logic             w_eval;

  assign w_change   = (w_sample != prev_q);
  assign w_cnt_next = w_change ? '0 : (cnt_q + 1'b1);
  assign w_settled  = (w_cnt_next >= CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SETTLE: begin
        cnt_d = w_cnt_next;
        if (w_settled) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Parked until the pattern moves: one evaluation per settled pattern.
        if (w_change) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_eval = 1'b0;
    case (state_q)
      ST_SETTLE: w_eval = w_settled;
      default:   w_eval = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Evaluation of the settled sample
  // --------------------------------------------------------------------------
  logic [3:0] w_an;
  logic [6:0] w_seg;
  logic [4:0] w_dec;
  logic       w_one_low;
  logic       w_multi_low;
  logic [1:0] w_idx;
  logic       w_capture;
  logic       w_bad_glyph;
  logic       w_timeout;

  assign w_an  = w_sample[10:7];
  assign w_seg = w_sample[6:0];
  assign w_dec = decode_glyph(w_seg);

  always_comb begin
    w_one_low = 1'b1;
    w_idx     = 2'd0;
    case (w_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_one_low = 1'b0;
    endcase
  end

  // Blank (4'hF) is neither one-low nor multi-low: nothing happens.
  assign w_multi_low = (w_an != 4'hF) && !w_one_low;
  assign w_capture   = w_eval && w_one_low && w_dec[4];
  assign w_bad_glyph = w_eval && w_one_low && !w_dec[4];

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------
  logic [3:0][3:0] d_q, d_d;
  logic [3:0]      valid_q, valid_d;
  logic [3:0]      glyph_err_q, glyph_err_d;
  logic            an_err_q, an_err_d;
  logic            upd_q, upd_d;
  logic [1:0]      upd_idx_q, upd_idx_d;

  // Ordering matters: clear and timeout first, then the evaluation so a
  // capture in the same cycle as clr survives for its own digit.
  always_comb begin
    d_d         = d_q;
    valid_d     = valid_q;
    glyph_err_d = glyph_err_q;
    upd_idx_d   = upd_idx_q;
    upd_d       = w_capture;
    an_err_d    = w_eval && w_multi_low;

    if (bus.clr) begin
      valid_d     = '0;
      glyph_err_d = '0;
    end
    if (w_timeout) begin
      valid_d = '0;
    end
    if (w_capture) begin
      d_d[w_idx]     = w_dec[3:0];
      valid_d[w_idx] = 1'b1;
      upd_idx_d      = w_idx;
    end
    if (w_bad_glyph) begin
      glyph_err_d[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= '0;
      valid_q     <= '0;
      glyph_err_q <= '0;
      an_err_q    <= 1'b0;
      upd_q       <= 1'b0;
      upd_idx_q   <= 2'd0;
    end else begin
      d_q         <= d_d;
      valid_q     <= valid_d;
      glyph_err_q <= glyph_err_d;
      an_err_q    <= an_err_d;
      upd_q       <= upd_d;
      upd_idx_q   <= upd_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Staleness watchdog
  // --------------------------------------------------------------------------
`ifdef DISP_CAP_TIMEOUT_EN
  localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             stale_q, stale_d;

  assign w_timeout = (tmo_q == TMO_MAX);

  always_comb begin
    tmo_d   = tmo_q;
    stale_d = stale_q;
    if (w_capture || bus.clr) begin
      tmo_d   = '0;
      stale_d = 1'b0;
    end else begin
      // Saturate so stale stays asserted until new data or clr arrives.
      if (!w_timeout) begin
        tmo_d = tmo_q + 1'b1;
      end else begin
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      stale_q <= stale_d;
    end
  end

  assign bus.stale = stale_q;
`else
  assign w_timeout = 1'b0;
  assign bus.stale = 1'b0;
`endif

  assign bus.d0        = d_q[0];
  assign bus.d1        = d_q[1];
  assign bus.d2        = d_q[2];
  assign bus.d3        = d_q[3];
  assign bus.valid     = valid_q;
  assign bus.glyph_err = glyph_err_q;
  assign bus.an_err    = an_err_q;
  assign bus.upd       = upd_q;
  assign bus.upd_idx   = upd_idx_q;

endmodule
`default_nettype wire
